// File: rtl/accsq_pkg.sv
// Shared definitions for the accumulate-then-square scheduler.
//   state_e    : scheduler FSM states
//   DW_DEFAULT : default operand/accumulator width
//   id_width() : width of a requester index (clog2 of the count, minimum 1)
package accsq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ADDSUB = 2'd1,
        ST_SQUARE = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    localparam int DW_DEFAULT = 32;

    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
//   req     : request vector
//   rr_ptr  : index with the highest priority this cycle
//   gnt_oh  : one-hot grant (zero when nothing requests)
//   gnt_idx : index of the granted bit (zero when nothing requests)
//   any_req : at least one request bit is set
// Search starts at rr_ptr and walks upward, wrapping past NREQ-1 to 0.
module rr_arbiter import accsq_pkg::*; #(
    parameter  int NREQ = 4,
    localparam int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [NREQ-1:0] gnt_oh,
    output logic [IDW-1:0]  gnt_idx,
    output logic            any_req
);

    int   idx;
    logic found;

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        any_req = |req;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found       = 1'b1;
                gnt_oh[idx] = 1'b1;
                gnt_idx     = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/accsq_rr_sched.sv
// Shares one add/sub-then-square datapath among NREQ requesters.
//   clk, rst_n   : clock, asynchronous active-low reset
//   req_valid    : per-requester request valid
//   req_ready    : per-requester accept strobe (one-hot, one cycle)
//   req_cond     : per-requester condition bit
//   req_operand  : per-requester operand, slice i at [i*DW +: DW]
//   rsp_valid    : result valid
//   rsp_ready    : result accepted
//   rsp_id       : requester index of the result
//   rsp_data     : updated accumulator value
//   clr          : synchronous clear of accumulators and direction history
//   busy         : FSM is outside IDLE
//   dbg_state    : current FSM state, for observation only
//
// Handshakes: a request transfers in the cycle where req_valid[i] and
// req_ready[i] are both high; req_ready is a grant decided from this
// cycle's req_valid and is never raised for a requester that is not
// valid. A response transfers in the cycle where rsp_valid and rsp_ready
// are both high; rsp_id/rsp_data hold still while rsp_valid waits.
module accsq_rr_sched import accsq_pkg::*; #(
    parameter  int NREQ   = 4,
    parameter  int DW     = DW_DEFAULT,
    parameter  int HIST_W = 10,
    localparam int IDW    = id_width(NREQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req_valid,
    output logic [NREQ-1:0]  req_ready,
    input  logic [NREQ-1:0]  req_cond,
    input  logic [NREQ*DW-1:0] req_operand,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [IDW-1:0]   rsp_id,
    output logic [DW-1:0]    rsp_data,
    input  logic             clr,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    state_e            state_q, state_d;
    logic [DW-1:0]     acc_q [NREQ];
    logic [DW-1:0]     acc_d [NREQ];
    logic [HIST_W-1:0] hist_q, hist_d;
    logic              dir_q, dir_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic              clr_pend_q, clr_pend_d;
    logic [DW-1:0]     op_q, op_d;
    logic              cond_q, cond_d;
    logic [IDW-1:0]    id_q, id_d;
    logic [DW-1:0]     sum_q, sum_d;
    logic [DW-1:0]     rsp_data_q, rsp_data_d;
    logic [IDW-1:0]    rsp_id_q, rsp_id_d;

    logic [NREQ-1:0]   gnt_oh;
    logic [IDW-1:0]    gnt_idx;
    logic              any_req;
    logic              grant_en;
    logic              dir_now;
    logic [DW-1:0]     sum_now;
    logic [DW-1:0]     prod;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (req_valid),
        .rr_ptr  (rr_ptr_q),
        .gnt_oh  (gnt_oh),
        .gnt_idx (gnt_idx),
        .any_req (any_req)
    );

    // A clear (new or pending) owns the IDLE cycle, so it blocks the grant.
    assign grant_en  = (state_q == ST_IDLE) && any_req && !clr && !clr_pend_q;
    assign req_ready = grant_en ? gnt_oh : '0;

    // Direction folds the previous direction, the parity of the recent
    // direction history and the requester's condition bit.
    assign dir_now = dir_q ^ (^hist_q) ^ cond_q;
    assign sum_now = dir_now ? (acc_q[id_q] + op_q) : (acc_q[id_q] - op_q);
    assign prod    = sum_q * sum_q;

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        hist_d     = hist_q;
        dir_d      = dir_q;
        rr_ptr_d   = rr_ptr_q;
        clr_pend_d = clr_pend_q;
        op_d       = op_q;
        cond_d     = cond_q;
        id_d       = id_q;
        sum_d      = sum_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;

        // A clear arriving mid-operation waits for the next IDLE cycle.
        if (clr && (state_q != ST_IDLE)) begin
            clr_pend_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (clr || clr_pend_q) begin
                    for (int i = 0; i < NREQ; i++) begin
                        acc_d[i] = '0;
                    end
                    hist_d     = '0;
                    dir_d      = 1'b0;
                    clr_pend_d = 1'b0;
                end else if (any_req) begin
                    op_d     = req_operand[int'(gnt_idx)*DW +: DW];
                    cond_d   = req_cond[gnt_idx];
                    id_d     = gnt_idx;
                    rr_ptr_d = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
                    state_d  = ST_ADDSUB;
                end
            end
            ST_ADDSUB: begin
                sum_d   = sum_now;
                dir_d   = dir_now;
                hist_d  = {hist_q[HIST_W-2:0], dir_now};
                state_d = ST_SQUARE;
            end
            ST_SQUARE: begin
                acc_d[id_q] = prod;
                rsp_data_d  = prod;
                rsp_id_d    = id_q;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            for (int i = 0; i < NREQ; i++) begin
                acc_q[i] <= '0;
            end
            hist_q     <= '0;
            dir_q      <= 1'b0;
            rr_ptr_q   <= '0;
            clr_pend_q <= 1'b0;
            op_q       <= '0;
            cond_q     <= 1'b0;
            id_q       <= '0;
            sum_q      <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            for (int i = 0; i < NREQ; i++) begin
                acc_q[i] <= acc_d[i];
            end
            hist_q     <= hist_d;
            dir_q      <= dir_d;
            rr_ptr_q   <= rr_ptr_d;
            clr_pend_q <= clr_pend_d;
            op_q       <= op_d;
            cond_q     <= cond_d;
            id_q       <= id_d;
            sum_q      <= sum_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
        end
    end

endmodule
